npc: RTL and testbench
======================

// Module: npc
// PURPOSE
//  Program-counter register plus next-PC logic for the single-cycle MIPS-style CPU.
//  Holds the current instruction address PC, which drives instruction_memory.
//  Computes NPC combinationally from sequential, branch or jump control.
//  Loads NPC into PC on every rising clock edge while write is enabled.
// PARAMETERS
//  RESET_PC  32'h0000_0000  value PC takes while reset is asserted
// PORTS
//  clk     in   1   single system clock; PC updates on posedge
//  reset   in   1   asynchronous, active-low reset (0 = reset)
//  branch  in   1   branch taken (control unit has already ANDed beq/bne with ALU zero)
//  jump    in   1   unconditional jump (j-format)
//  imm32   in   32  sign-extended 16-bit branch offset, in words
//  imm26   in   26  jump target field, in words
//  PCwrt   in   1   PC write enable; 0 freezes PC (halt)
//  PC      out  32  current PC, registered, byte address
//  NPC     out  32  next PC, combinational from PC and controls
// BEHAVIOUR
//  - Byte addressing; instructions are word aligned; PC[1:0] is always 2'b00.
//  - seq  = PC + 32'd4, modulo 2^32 (0xFFFF_FFFC + 4 -> 0x0000_0000).
//  - btgt = seq + (imm32 << 2), modulo 2^32. Negative imm32 branches backward.
//  - jtgt = {seq[31:28], imm26, 2'b00}.
//  - NPC priority: jump -> jtgt; else branch -> btgt; else seq.
//    If jump and branch are both 1, jump wins.
//  - NPC is purely combinational. It has no registered latency and settles within the cycle.
//  - reset==0: PC = RESET_PC immediately (async), regardless of clk and PCwrt.
//    NPC follows combinationally and reads RESET_PC+4 with no control asserted.
//  - reset==1 at posedge clk: if PCwrt==1, PC <= NPC; if PCwrt==0, PC holds.
//  - Reset deassertion is synchronised externally. The first update after release is
//    at the next posedge.
//  - Controls are sampled only at posedge. They are driven on negedge by the datapath and bench.
//  - No X propagation: every output is defined from reset onward.
// STRUCTURE
//  - Shared cpu package: WORD_W=32, RESET_PC default, instruction field widths (IMM16_W=16, IMM26_W=26).
//  - One natural sub-module: npc_calc (combinational seq/btgt/jtgt and priority mux).
//    The top level holds only the PC flop with async active-low reset and PCwrt enable.
// TESTING
//  1 Reset: reset=0 mid-cycle with PC=0x40 -> PC=0x0 at once, NPC=0x4. Release, no controls
//    -> PC = 4, 8, 12 on successive posedges.
//  2 Branch: PC=0x10, branch=1, imm32=0x3 -> NPC=0x20. imm32=0xFFFF_FFFE -> NPC=0xC.
//  3 Jump: PC=0x1000_0004, jump=1, imm26=0x000_0040 -> NPC=0x1000_0100.
//    Same values with branch=1 also set -> still 0x1000_0100.
//  4 Halt: PCwrt=0 for 3 posedges at PC=0x8 -> PC stays 0x8 while NPC=0xC.
//    PCwrt=1 -> PC=0xC at the next posedge.
//  5 Wrap: PC=0xFFFF_FFFC, no controls -> NPC=0x0.
//    branch=1, imm32=1 -> NPC=0x4.
//  6 Randomised: 1000 cycles of random controls and immediates; PC checked each posedge
//    against a reference model.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared CPU constants: datapath width, reset vector and instruction field widths.
package npc_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned IMM16_W = 16;
  localparam int unsigned IMM26_W = 26;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// Next-PC arithmetic: sequential, branch and jump targets plus priority select.
module npc_calc
  import npc_pkg::*;
(
  input  logic [WORD_W-1:0]  pc_i,
  input  logic               branch_i,
  input  logic               jump_i,
  input  logic [WORD_W-1:0]  imm32_i,
  input  logic [IMM26_W-1:0] imm26_i,
  output logic [WORD_W-1:0]  npc_o
);

  logic [WORD_W-1:0] seq;
  logic [WORD_W-1:0] btgt;
  logic [WORD_W-1:0] jtgt;

  // Offsets are in words; the shift drops the two top bits, giving modulo-2^32 wrap.
  assign seq  = pc_i + 32'd4;
  assign btgt = seq + (imm32_i << 2);
  assign jtgt = {seq[WORD_W-1:WORD_W-4], imm26_i, 2'b00};

  always_comb begin
    npc_o = seq;
    if (jump_i) begin
      npc_o = jtgt;
    end else if (branch_i) begin
      npc_o = btgt;
    end
  end

endmodule

// File: rtl/npc.sv
// Program counter register with async active-low reset and write enable.
module npc
  import npc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch,
  input  logic               jump,
  input  logic [WORD_W-1:0]  imm32,
  input  logic [IMM26_W-1:0] imm26,
  input  logic               PCwrt,
  output logic [WORD_W-1:0]  PC,
  output logic [WORD_W-1:0]  NPC
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;

  npc_calc u_calc (
    .pc_i     (pc_q),
    .branch_i (branch),
    .jump_i   (jump),
    .imm32_i  (imm32),
    .imm26_i  (imm26),
    .npc_o    (NPC)
  );

  assign pc_d = PCwrt ? NPC : pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_npc.sv
// Directed and randomised checks of the PC register and next-PC selection.
module tb_npc;

  logic        clk;
  logic        reset;
  logic        branch;
  logic        jump;
  logic [31:0] imm32;
  logic [25:0] imm26;
  logic        PCwrt;
  logic [31:0] PC;
  logic [31:0] NPC;

  int          n_cmp;
  int          n_mis;
  logic [31:0] cur_pc;

  npc dut (
    .clk    (clk),
    .reset  (reset),
    .branch (branch),
    .jump   (jump),
    .imm32  (imm32),
    .imm26  (imm26),
    .PCwrt  (PCwrt),
    .PC     (PC),
    .NPC    (NPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive controls on the falling edge, then let NPC settle.
  task automatic apply(input logic b, input logic j, input logic [31:0] i32,
                       input logic [25:0] i26, input logic w);
    @(negedge clk);
    branch = b;
    jump   = j;
    imm32  = i32;
    imm26  = i26;
    PCwrt  = w;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reach any aligned address with a single taken branch from the current PC.
  task automatic goto_pc(input logic [31:0] tgt);
    logic [31:0] diff;
    diff = tgt - cur_pc - 32'd4;
    apply(1'b1, 1'b0, diff >> 2, 26'd0, 1'b1);
    step();
    chk("goto", PC, tgt);
    cur_pc = tgt;
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic b, input logic j,
                                          input logic [31:0] i32, input logic [25:0] i26);
    logic [31:0] s;
    s = pc + 32'd4;
    if (j)      return {s[31:28], i26, 2'b00};
    else if (b) return s + {i32[29:0], 2'b00};
    else        return s;
  endfunction

  initial begin
    logic        rb, rj, rw;
    logic [31:0] ri32;
    logic [25:0] ri26;
    logic [31:0] exp_npc;

    n_cmp  = 0;
    n_mis  = 0;
    reset  = 1'b0;
    branch = 1'b0;
    jump   = 1'b0;
    imm32  = '0;
    imm26  = '0;
    PCwrt  = 1'b1;
    #3;
    chk("rst_pc", PC, 32'h0000_0000);
    chk("rst_npc", NPC, 32'h0000_0004);

    @(negedge clk);
    reset  = 1'b1;
    PCwrt  = 1'b0;
    cur_pc = 32'h0;

    // Reset asserted mid-cycle from a non-zero PC.
    goto_pc(32'h0000_0040);
    apply(1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", PC, 32'h0000_0000);
    chk("async_rst_npc", NPC, 32'h0000_0004);
    @(negedge clk);
    reset  = 1'b1;
    cur_pc = 32'h0;
    apply(1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
    step();
    chk("seq_1", PC, 32'h0000_0004);
    step();
    chk("seq_2", PC, 32'h0000_0008);
    step();
    chk("seq_3", PC, 32'h0000_000C);
    cur_pc = 32'h0000_000C;

    // Branch forward and backward.
    goto_pc(32'h0000_0010);
    apply(1'b1, 1'b0, 32'h0000_0003, 26'h0, 1'b0);
    chk("br_fwd_npc", NPC, 32'h0000_0020);
    apply(1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0, 1'b0);
    chk("br_back_npc", NPC, 32'h0000_000C);
    chk("br_hold_pc", PC, 32'h0000_0010);
    apply(1'b1, 1'b0, 32'h0000_0003, 26'h0, 1'b1);
    step();
    chk("br_fwd_pc", PC, 32'h0000_0020);
    cur_pc = 32'h0000_0020;

    // Jump, and jump beating a simultaneous branch.
    goto_pc(32'h1000_0004);
    apply(1'b0, 1'b1, 32'h0, 26'h000_0040, 1'b0);
    chk("jmp_npc", NPC, 32'h1000_0100);
    apply(1'b1, 1'b1, 32'h0, 26'h000_0040, 1'b0);
    chk("jmp_over_br_npc", NPC, 32'h1000_0100);
    apply(1'b1, 1'b1, 32'h0000_0003, 26'h000_0040, 1'b1);
    step();
    chk("jmp_pc", PC, 32'h1000_0100);
    cur_pc = 32'h1000_0100;

    // Halt: PC frozen for three edges, then resumes.
    goto_pc(32'h0000_0008);
    apply(1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("halt_pc", PC, 32'h0000_0008);
      chk("halt_npc", NPC, 32'h0000_000C);
    end
    apply(1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
    step();
    chk("resume_pc", PC, 32'h0000_000C);
    cur_pc = 32'h0000_000C;

    // Address wrap at the top of memory.
    goto_pc(32'hFFFF_FFFC);
    apply(1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
    chk("wrap_seq_npc", NPC, 32'h0000_0000);
    apply(1'b1, 1'b0, 32'h0000_0001, 26'h0, 1'b0);
    chk("wrap_br_npc", NPC, 32'h0000_0004);
    apply(1'b1, 1'b0, 32'h0000_0001, 26'h0, 1'b1);
    step();
    chk("wrap_br_pc", PC, 32'h0000_0004);
    cur_pc = 32'h0000_0004;

    // Randomised controls against the reference model.
    for (int n = 0; n < 1000; n++) begin
      rb   = 1'($urandom_range(0, 1));
      rj   = ($urandom_range(0, 3) == 0);
      rw   = ($urandom_range(0, 9) != 0);
      ri32 = $urandom();
      ri26 = 26'($urandom());
      apply(rb, rj, ri32, ri26, rw);
      exp_npc = ref_npc(cur_pc, rb, rj, ri32, ri26);
      chk("rnd_npc", NPC, exp_npc);
      step();
      if (rw) cur_pc = exp_npc;
      chk("rnd_pc", PC, cur_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
